// File: rtl/byte_striping_tx.sv
// byte_striping_tx
//   Transmit-side byte striper. A single byte stream at the fast clock is
//   split alternately onto two lanes (lane 0 first). Each lane updates once
//   every two fast-clock cycles; lane_strobe marks the first cycle of every
//   new lane value so downstream logic needs no second clock.
//
// Ports
//   clk_2f          fast clock, the only clock
//   reset           synchronous, active-high reset
//   data_in         input byte
//   valid_in        data_in carries a byte this cycle
//   data_stripe_0   lane 0 byte (registered)
//   data_stripe_1   lane 1 byte (registered)
//   valid_stripe_0  lane 0 byte valid
//   valid_stripe_1  lane 1 byte valid
//   lane_strobe     one-cycle pulse in the first cycle of each lane value
//   byte_count      bytes accepted since reset, wraps modulo 2^CNT_W
module byte_striping_tx #(
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0]  IDLE   = 8'hBC,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_stripe_0,
  output logic [DATA_W-1:0] data_stripe_1,
  output logic              valid_stripe_0,
  output logic              valid_stripe_1,
  output logic              lane_strobe,
  output logic [CNT_W-1:0]  byte_count
);

  // Capture phase holds the first byte of a pair; emit phase drives both lanes.
  typedef enum logic {
    PH_CAPTURE = 1'b0,
    PH_EMIT    = 1'b1
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   lane0_q, lane0_d;
  logic [DATA_W-1:0]   lane1_q, lane1_d;
  logic                lane0_valid_q, lane0_valid_d;
  logic                lane1_valid_q, lane1_valid_d;
  logic                strobe_q, strobe_d;
  logic [CNT_W-1:0]    count_q, count_d;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase_q       <= PH_CAPTURE;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      lane0_q       <= '0;
      lane1_q       <= '0;
      lane0_valid_q <= 1'b0;
      lane1_valid_q <= 1'b0;
      strobe_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      phase_q       <= phase_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      lane0_q       <= lane0_d;
      lane1_q       <= lane1_d;
      lane0_valid_q <= lane0_valid_d;
      lane1_valid_q <= lane1_valid_d;
      strobe_q      <= strobe_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    phase_d       = PH_CAPTURE;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    lane0_d       = lane0_q;
    lane1_d       = lane1_q;
    lane0_valid_d = lane0_valid_q;
    lane1_valid_d = lane1_valid_q;
    strobe_d      = 1'b0;
    count_d       = valid_in ? count_q + CNT_W'(1) : count_q;

    unique case (phase_q)
      PH_CAPTURE: begin
        phase_d      = PH_EMIT;
        hold_valid_d = valid_in;
        if (valid_in) begin
          hold_d = data_in;
        end
      end
      PH_EMIT: begin
        phase_d      = PH_CAPTURE;
        strobe_d     = 1'b1;
        hold_valid_d = 1'b0;
        // Lane 0 always takes the oldest byte of the frame so the merger,
        // which favours lane 0, rebuilds the original order.
        if (hold_valid_q) begin
          lane0_d       = hold_q;
          lane0_valid_d = 1'b1;
          lane1_d       = valid_in ? data_in : IDLE;
          lane1_valid_d = valid_in;
        end else begin
          lane0_d       = valid_in ? data_in : IDLE;
          lane0_valid_d = valid_in;
          lane1_d       = IDLE;
          lane1_valid_d = 1'b0;
        end
      end
      default: phase_d = PH_CAPTURE;
    endcase
  end

  assign data_stripe_0  = lane0_q;
  assign data_stripe_1  = lane1_q;
  assign valid_stripe_0 = lane0_valid_q;
  assign valid_stripe_1 = lane1_valid_q;
  assign lane_strobe    = strobe_q;
  assign byte_count     = count_q;

endmodule

// File: tb/tb_byte_striping_tx.sv
module tb_byte_striping_tx;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;

  logic [7:0]  d0, d1;
  logic        v0, v1, st;
  logic [15:0] cnt16;

  logic [7:0]  d0_w, d1_w;
  logic        v0_w, v1_w, st_w;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-based reference model: bytes accepted in a two-cycle frame are
  // collected in a queue and laid out on the lanes when the frame closes.
  bit          m_phase;       // phase of the next cycle to be driven
  logic [7:0]  m_frame[$];
  logic [7:0]  e_d0, e_d1;
  logic        e_v0, e_v1, e_st;
  logic [15:0] e_cnt16;
  logic [3:0]  e_cnt4;

  always #5 clk_2f = ~clk_2f;

  byte_striping_tx dut (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_stripe_0(d0), .data_stripe_1(d1),
    .valid_stripe_0(v0), .valid_stripe_1(v1),
    .lane_strobe(st), .byte_count(cnt16)
  );

  byte_striping_tx #(.DATA_W(8), .IDLE(8'hBC), .CNT_W(4)) dut_w4 (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_stripe_0(d0_w), .data_stripe_1(d1_w),
    .valid_stripe_0(v0_w), .valid_stripe_1(v1_w),
    .lane_strobe(st_w), .byte_count(cnt4)
  );

  // Apply one cycle of stimulus, advance the model at the edge, settle 1ns.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    reset    = r;
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    if (r) begin
      m_phase = 1'b0;
      m_frame.delete();
      {e_d0, e_d1, e_v0, e_v1, e_st} = '0;
      e_cnt16 = '0;
      e_cnt4  = '0;
    end else begin
      if (v) begin
        m_frame.push_back(d);
        e_cnt16 = e_cnt16 + 16'd1;
        e_cnt4  = e_cnt4 + 4'd1;
      end
      if (m_phase) begin
        e_d0 = (m_frame.size() >= 1) ? m_frame[0] : 8'hBC;
        e_v0 = (m_frame.size() >= 1);
        e_d1 = (m_frame.size() == 2) ? m_frame[1] : 8'hBC;
        e_v1 = (m_frame.size() == 2);
        e_st = 1'b1;
        m_frame.delete();
      end else begin
        e_st = 1'b0;
      end
      m_phase = ~m_phase;
    end
    #1;
  endtask

  task automatic align_phase0();
    if (m_phase) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'hFF);
      n_checks++;
      if ({d0, d1, v0, v1, st, cnt16} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got d0=%h d1=%h v=%b%b st=%b cnt=%0d, want all 0",
                 d0, d1, v0, v1, st, cnt16);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({d0, d1, v0, v1, st} !== {e_d0, e_d1, e_v0, e_v1, e_st} || cnt16 !== e_cnt16) begin
        n_fail++;
        $display("FAIL reset_release_idle[%0d]: got %h %h %b%b st=%b cnt=%0d, want %h %h %b%b st=%b cnt=%0d",
                 i, d0, d1, v0, v1, st, cnt16, e_d0, e_d1, e_v0, e_v1, e_st, e_cnt16);
      end
    end
    n_checks++;
    if ({d0, d1, v0, v1, st} !== {8'hBC, 8'hBC, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL idle_lanes: got %h %h %b%b st=%b, want bc bc 00 st=1", d0, d1, v0, v1, st);
    end
  endtask

  task automatic test_stream();
    align_phase0();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) cycle(1'b0, 1'b1, 8'(i));
      else        cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({d0, d1, v0, v1, st} !== {e_d0, e_d1, e_v0, e_v1, e_st} || cnt16 !== e_cnt16) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h %h %b%b st=%b cnt=%0d, want %h %h %b%b st=%b cnt=%0d",
                 i, d0, d1, v0, v1, st, cnt16, e_d0, e_d1, e_v0, e_v1, e_st, e_cnt16);
      end
      if (i == 9) begin
        n_checks++;
        if ({d0, d1, v0, v1} !== {8'h07, 8'h08, 2'b11} || cnt16 !== 16'd8) begin
          n_fail++;
          $display("FAIL stream_last_pair: got %h %h %b%b cnt=%0d, want 07 08 11 cnt=8",
                   d0, d1, v0, v1, cnt16);
        end
      end
    end
  endtask

  task automatic test_odd_burst();
    logic [7:0] burst[3];
    burst = '{8'hA0, 8'hA1, 8'hA2};
    align_phase0();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) cycle(1'b0, 1'b1, burst[i]);
      else       cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({d0, d1, v0, v1, st} !== {e_d0, e_d1, e_v0, e_v1, e_st}) begin
        n_fail++;
        $display("FAIL odd_burst[%0d]: got %h %h %b%b st=%b, want %h %h %b%b st=%b",
                 i, d0, d1, v0, v1, st, e_d0, e_d1, e_v0, e_v1, e_st);
      end
      if (i == 3) begin
        n_checks++;
        if ({d0, d1, v0, v1} !== {8'hA2, 8'hBC, 2'b10}) begin
          n_fail++;
          $display("FAIL odd_pad: got %h %h %b%b, want a2 bc 10", d0, d1, v0, v1);
        end
      end
    end
  endtask

  task automatic test_single_phase1();
    align_phase0();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h55);
    n_checks++;
    if ({d0, d1, v0, v1, st} !== {8'h55, 8'hBC, 2'b10, 1'b1} ||
        {d0, d1, v0, v1, st} !== {e_d0, e_d1, e_v0, e_v1, e_st}) begin
      n_fail++;
      $display("FAIL single_phase1: got %h %h %b%b st=%b, want 55 bc 10 st=1", d0, d1, v0, v1, st);
    end
  endtask

  task automatic test_reset_midpair();
    align_phase0();
    cycle(1'b0, 1'b1, 8'h33);
    cycle(1'b1, 1'b1, 8'h44);
    n_checks++;
    if ({d0, d1, v0, v1, st, cnt16, cnt4} !== '0) begin
      n_fail++;
      $display("FAIL reset_midpair: got %h %h %b%b st=%b cnt=%0d cnt4=%0d, want all 0",
               d0, d1, v0, v1, st, cnt16, cnt4);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if (d0 === 8'h33 || d1 === 8'h33 ||
          {d0, d1, v0, v1, st} !== {e_d0, e_d1, e_v0, e_v1, e_st}) begin
        n_fail++;
        $display("FAIL reset_midpair_after[%0d]: got %h %h %b%b st=%b, want %h %h %b%b st=%b",
                 i, d0, d1, v0, v1, st, e_d0, e_d1, e_v0, e_v1, e_st);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 19; i++) begin
      if (i < 17) cycle(1'b0, 1'b1, 8'($urandom));
      else        cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({d0_w, d1_w, v0_w, v1_w, st_w} !== {e_d0, e_d1, e_v0, e_v1, e_st} ||
          cnt4 !== e_cnt4 || cnt16 !== e_cnt16) begin
        n_fail++;
        $display("FAIL cnt_wrap[%0d]: got w4 %h %h %b%b st=%b cnt4=%0d cnt=%0d, want %h %h %b%b st=%b cnt4=%0d cnt=%0d",
                 i, d0_w, d1_w, v0_w, v1_w, st_w, cnt4, cnt16,
                 e_d0, e_d1, e_v0, e_v1, e_st, e_cnt4, e_cnt16);
      end
    end
    n_checks++;
    if (cnt4 !== 4'd1 || cnt16 !== 16'd17) begin
      n_fail++;
      $display("FAIL cnt_wrap_value: got cnt4=%0d cnt=%0d, want cnt4=1 cnt=17", cnt4, cnt16);
    end
  endtask

  task automatic test_random();
    logic r, v;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      cycle(r, v, 8'($urandom));
      n_checks++;
      if ({d0, d1, v0, v1, st} !== {e_d0, e_d1, e_v0, e_v1, e_st} || cnt16 !== e_cnt16 ||
          {d0_w, d1_w, v0_w, v1_w, st_w} !== {e_d0, e_d1, e_v0, e_v1, e_st} || cnt4 !== e_cnt4) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h %h %b%b st=%b cnt=%0d cnt4=%0d, want %h %h %b%b st=%b cnt=%0d cnt4=%0d",
                 i, d0, d1, v0, v1, st, cnt16, cnt4, e_d0, e_d1, e_v0, e_v1, e_st, e_cnt16, e_cnt4);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    m_phase  = 1'b0;
    {e_d0, e_d1, e_v0, e_v1, e_st} = '0;
    e_cnt16  = '0;
    e_cnt4   = '0;
    test_reset();
    test_stream();
    test_odd_burst();
    test_single_phase1();
    test_reset_midpair();
    test_cnt_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_striping_tx.md
Name: byte_striping_tx

Overview:
- Transmit-side byte striper: takes one byte stream at the fast clock and distributes consecutive bytes alternately onto two output lanes (lane 0 first), each lane updating once per two fast-clock cycles.
- Feeds the two-lane physical path.
- The striped lanes are consumed by the lane-merging (unstriping) block at the far end, which rebuilds the original byte order by giving lane 0 priority.
- Single-clock design: the half-rate lane timing is carried by a one-cycle strobe, not a second clock.

Parameters:
- DATA_W, 8, byte width of input and each lane.
- IDLE, 8'hBC, value driven on a lane's data when that lane's valid is low after the first lane update.
- CNT_W, 16, width of the accepted-byte counter (wraps modulo 2^CNT_W).

Ports:
- clk_2f  input  1  fast clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  byte stream in.
- valid_in  input  1  data_in holds a byte this cycle.
- data_stripe_0  output  DATA_W  lane 0 byte; registered.
- data_stripe_1  output  DATA_W  lane 1 byte; registered.
- valid_stripe_0  output  1  lane 0 byte valid.
- valid_stripe_1  output  1  lane 1 byte valid.
- lane_strobe  output  1  one-cycle pulse in the first cycle of each new lane value (half-rate frame marker).
- byte_count  output  CNT_W  number of bytes accepted since reset.

Behaviour:
- Reset (sampled on posedge clk_2f while reset=1):
  - phase=0, hold_valid=0.
  - data_stripe_0/1=0, valid_stripe_0/1=0, lane_strobe=0, byte_count=0.
  - Any held byte is discarded; reset mid-pair loses that byte.
- Phase: 1-bit register, toggles every cycle after reset release. The first cycle with reset=0 is phase 0.
- Phase 0 cycle:
  - If valid_in, data_in is captured into hold register and hold_valid<=1; otherwise hold_valid<=0.
  - Lane outputs hold their values.
- Phase 1 cycle: at the closing edge, the lanes update together and lane_strobe<=1 for the next cycle.
  - hold_valid=1, valid_in=1: lane0<=hold, lane1<=data_in, both valid=1.
  - hold_valid=1, valid_in=0: lane0<=hold valid=1; lane1<=IDLE valid=0 (odd-length pad).
  - hold_valid=0, valid_in=1: lane0<=data_in valid=1; lane1<=IDLE valid=0. Lane 0 has priority, which preserves order for the merger.
  - hold_valid=0, valid_in=0: both lanes<=IDLE, valid=0.
  - hold_valid cleared at the same edge.
- lane_strobe:
  - High exactly in the cycle after each phase-1 edge, i.e. the phase-0 cycles.
  - Period 2, never two consecutive highs.
  - Low during reset and in the first cycle after release.
- Latency:
  - A phase-0 byte at cycle t is visible on lane 0 from cycle t+2.
  - A phase-1 byte at cycle t is visible from cycle t+1.
  - Lane values are stable for exactly 2 cycles.
- byte_count:
  - Increments by 1 on every edge with valid_in=1 and reset=0.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- No backpressure: a byte is accepted every cycle valid_in=1. Throughput is 2 bytes per lane update, so no byte is ever dropped except by reset.
- Reset asserted together with valid_in: the byte is not counted or captured, and phase returns to 0.

Test Plan:
- Reset held 3 cycles, then idle 4 cycles -> all outputs 0 during reset. After release: lanes=8'hBC, valids=0, lane_strobe pulses every 2nd cycle starting 2 cycles after release.
- Continuous stream 8'h01..8'h08 starting on a phase-0 cycle -> lane pairs (01,02),(03,04),(05,06),(07,08), both valids=1, each held 2 cycles; byte_count=8.
- Odd burst 8'hA0,8'hA1,8'hA2 then idle -> (A0,A1) valid 1/1, then (A2,BC) valid 1/0, then (BC,BC) valid 0/0.
- Single byte 8'h55 arriving on a phase-1 cycle with nothing held -> lane0=55 valid=1, lane1=BC valid=0, visible the next cycle.
- Reset asserted on the phase-1 cycle after 8'h33 was held at phase 0 -> 8'h33 never appears on any lane; all outputs 0; byte_count=0.
- CNT_W=4 override, 17 valid bytes -> byte_count reads 1 after wrap, and lane data remains correctly paired throughout.
